booth_mult_ctrl: RTL

Sequential signed 32×32 multiplier engine for the processor's multdiv unit. It uses radix-4 Booth recoding and runs a fixed 16-step iteration, timed by an internal 4-bit step counter. It accepts a one-cycle start pulse from the pipeline's multdiv stall logic and returns a registered 32-bit result with an overflow exception flag. It holds the pipeline busy flag high while iterating.

---
 rtl/multdiv_pkg.sv | 44 ++++
 rtl/booth_radix4_sel.sv | 31 +++
 rtl/booth_mult_ctrl.sv | 101 ++++++++++
 3 files changed

// File: rtl/multdiv_pkg.sv
// Shared types for the multdiv unit: FSM encoding, widths, Booth digit decode.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package multdiv_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_STEPS = MD_WIDTH / 2;
    localparam int ACC_W    = MD_WIDTH + 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    typedef enum logic [2:0] {
        BD_ZERO = 3'd0,
        BD_POS1 = 3'd1,
        BD_POS2 = 3'd2,
        BD_NEG2 = 3'd3,
        BD_NEG1 = 3'd4
    } booth_dig_t;

    // acc carries two guard bits so +/-2M never wraps during accumulation.
    typedef struct packed {
        logic [ACC_W-1:0]    acc;
        logic [MD_WIDTH-1:0] q;
        logic                q_m1;
    } prod_reg_t;

    function automatic booth_dig_t booth_decode(input logic [2:0] bits);
        booth_dig_t dig;
        dig = BD_ZERO;
        case (bits)
            3'b001, 3'b010: dig = BD_POS1;
            3'b011:         dig = BD_POS2;
            3'b100:         dig = BD_NEG2;
            3'b101, 3'b110: dig = BD_NEG1;
            default:        dig = BD_ZERO;
        endcase
        return dig;
    endfunction

endpackage

// File: rtl/booth_radix4_sel.sv
// Radix-4 Booth addend selector: maps {q[1:0], q_m1} to d*M, sign-extended.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module booth_radix4_sel
    import multdiv_pkg::*;
(
    input  logic [2:0]          booth_bits,
    input  logic [MD_WIDTH-1:0] m_dat,
    output logic [ACC_W-1:0]    addend_dat
);

    logic [ACC_W-1:0] m_ext;
    logic [ACC_W-1:0] m_x2;
    booth_dig_t       dig;

    assign m_ext = {{2{m_dat[MD_WIDTH-1]}}, m_dat};
    assign m_x2  = {m_ext[ACC_W-2:0], 1'b0};
    assign dig   = booth_decode(booth_bits);

    always_comb begin
        addend_dat = '0;
        case (dig)
            BD_POS1: addend_dat = m_ext;
            BD_POS2: addend_dat = m_x2;
            BD_NEG1: addend_dat = ~m_ext + 1'b1;
            BD_NEG2: addend_dat = ~m_x2 + 1'b1;
            default: addend_dat = '0;
        endcase
    end

endmodule

// File: rtl/booth_mult_ctrl.sv
// Sequential signed 32x32 radix-4 Booth multiplier with overflow flag.
// Latency: 16 cycles start-to-RDY; busy for 17 cycles; 18-cycle start spacing.
// Backpressure: none; starts arriving while busy are dropped, not queued.
module booth_mult_ctrl
    import multdiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int STEPS = MD_STEPS
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ctrl_MULT,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int STEP_W = $clog2(STEPS);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

    state_t             state;
    logic [STEP_W-1:0]  step;
    prod_reg_t          p_reg;
    logic [WIDTH-1:0]   m_reg;

    logic [ACC_W-1:0]   addend_dat;
    logic [ACC_W-1:0]   acc_sum;
    prod_reg_t          p_nxt;
    logic [WIDTH:0]     hi_bits;
    logic               ovf;

    booth_radix4_sel u_sel (
        .booth_bits (p_reg.q[1:0] == 2'b00 ? {2'b00, p_reg.q_m1} : {p_reg.q[1:0], p_reg.q_m1}),
        .m_dat      (m_reg),
        .addend_dat (addend_dat)
    );

    // Add then arithmetic-shift the full {acc, q, q_m1} right by two.
    always_comb begin
        acc_sum    = p_reg.acc + addend_dat;
        p_nxt.acc  = {{2{acc_sum[ACC_W-1]}}, acc_sum[ACC_W-1:2]};
        p_nxt.q    = {acc_sum[1:0], p_reg.q[WIDTH-1:2]};
        p_nxt.q_m1 = p_reg.q[1];
    end

    // Product fits in 32 signed bits only if bits 63..31 are a pure sign run.
    assign hi_bits = {p_nxt.acc[WIDTH-1:0], p_nxt.q[WIDTH-1]};
    assign ovf     = !((hi_bits == '0) || (hi_bits == '1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            step           <= '0;
            p_reg          <= '0;
            m_reg          <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    data_resultRDY <= 1'b0;
                    if (ctrl_MULT) begin
                        m_reg      <= data_operandA;
                        p_reg.acc  <= '0;
                        p_reg.q    <= data_operandB;
                        p_reg.q_m1 <= 1'b0;
                        step       <= '0;
                        busy       <= 1'b1;
                        state      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    p_reg <= p_nxt;
                    step  <= step + 1'b1;
                    if (step == LAST_STEP) begin
                        data_result    <= p_nxt.q;
                        data_exception <= ovf;
                        data_resultRDY <= 1'b1;
                        state          <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    data_resultRDY <= 1'b0;
                    busy           <= 1'b0;
                    state          <= ST_IDLE;
                end
                default: begin
                    data_resultRDY <= 1'b0;
                    busy           <= 1'b0;
                    state          <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
